str_cic_chan_arb: RTL and testbench
===================================

# str_cic_chan_arb

Round-robin stream arbiter that time-shares one streaming CIC decimator among CH input sample streams. It grants one channel at a time for a burst of exactly BURST samples, so that every decimation frame is built from a single channel. It registers the selected sample with its channel tag and a last-of-burst flag toward the shared filter input. It sits between the per-channel ADC capture streams and the shared decimator in the LPDAQ front end.

## Interface
- W, default 10: sample width.
- CH, default 4: number of requesting channels, legal range 2..16.
- BURST, default 4: samples per grant. Set equal to the decimator rate R.
- IDW, derived as $clog2(CH): channel-tag width.

Ports:
- clk  in  1  single clock. All logic is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_axis_tdata  in  CH×W  packed per-channel signed samples. Channel i occupies bits [i*W +: W].
- s_axis_tvalid  in  CH  per-channel valid.
- s_axis_tready  out  CH  per-channel ready. One-hot or all-zero.
- m_axis_tdata  out  W  signed sample to the shared decimator.
- m_axis_tid  out  IDW  channel tag of m_axis_tdata.
- m_axis_tlast  out  1  high on the BURST-th sample of a grant.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- busy  out  1  high while in state LOCK.

## Operation
- Handshake definitions:
  - ish = s_axis_tvalid[g] & s_axis_tready[g].
  - osh = m_axis_tvalid & m_axis_tready.
- Output register ready: oreg_rdy = osh | ~m_axis_tvalid.
- State IDLE:
  - Scan channels ptr, ptr+1, …, ptr+CH-1, modulo CH.
  - Choose the first channel with tvalid=1 as g, and clear cnt to 0.
  - If a channel is found, go to LOCK. Otherwise stay in IDLE.
  - All s_axis_tready are 0 in IDLE.
- State LOCK:
  - s_axis_tready[g] = oreg_rdy. All other ready bits are 0.
  - On ish:
    - m_axis_tdata ← sample of channel g.
    - m_axis_tid ← g.
    - m_axis_tlast ← (cnt == BURST-1).
    - m_axis_tvalid ← 1.
    - cnt ← cnt+1.
  - On ish with cnt == BURST-1:
    - ptr ← (g+1) mod CH, wrapping CH-1 → 0.
    - Go to IDLE.
- Output valid update: on osh without ish, m_axis_tvalid ← 0. On simultaneous osh and ish, new data is loaded and valid stays 1.
- No preemption:
  - A granted channel keeps the grant until BURST samples are taken, even if its tvalid drops.
  - While its tvalid is low, the arbiter waits and other channels are not served.
- Output register behaviour:
  - The output register holds its contents while m_axis_tvalid=1 and m_axis_tready=0.
  - m_axis_tdata, m_axis_tid and m_axis_tlast never change while the output is stalled.
- cnt width is $clog2(BURST+1). ptr and g are IDW bits wide.
- Data passes through unmodified. There is no arithmetic on samples.

## Timing
- Reset values, applied asynchronously on rst_n=0:
  - State IDLE, ptr=0, g=0, cnt=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tlast=0.
  - busy=0, s_axis_tready all 0.
- Reset deassertion is used synchronously. The first arbitration happens on the first rising edge with rst_n=1.
- Arbitration latency: an IDLE cycle with a valid request moves to LOCK on that edge. The earliest ready for the first sample is the next cycle.
- Data latency: one cycle from ish to m_axis_tvalid.
- Throughput: BURST samples per BURST+1 cycles maximum, because of one IDLE arbitration cycle between grants.
- Reset in mid-burst: the partial burst is discarded and the output is invalidated immediately. After reset, arbitration restarts at channel 0.
- Simultaneous requests: in IDLE, the lowest index at or after ptr (modulo CH) wins.

## Test plan
- **Single channel, no backpressure.** CH=4, BURST=4, only ch2 valid with samples 1,2,3,4,5. Required response:
  - Output 1,2,3,4 with tid=2 and tlast on 4.
  - One idle cycle, then 5 starts a new burst with tid=2.
- **All channels valid, continuous.** Required response:
  - Bursts are granted in order tid 0,1,2,3,0.
  - Each burst has exactly 4 samples, and tlast is set only on the 4th.
- **Backpressure.** Hold m_axis_tready=0 for 3 cycles mid-burst. Required response:
  - m_axis_tdata, tid and tlast remain stable.
  - s_axis_tready[g]=0 while the output register is full and stalled.
  - No sample is lost or duplicated when tready returns to 1.
- **Grant holding.** Granted ch1 drops tvalid after 2 samples while ch3 is valid. Required response:
  - Grant stays on ch1 and ch3 ready stays 0.
  - ch1 resumes and delivers samples 3 and 4, then ch3 is granted.
- **Wrap-around and priority.** After a ch3 burst, ch0 and ch2 are both valid. Required response: ch0 is granted (ptr wrapped to 0).
- **Asynchronous reset mid-burst.** Assert rst_n=0 after 2 samples of a ch1 burst, between clock edges. Required response:
  - m_axis_tvalid=0, busy=0 and all ready bits 0 immediately, without waiting for an edge.
  - After release with ch1 and ch0 valid, ch0 is granted first.

Source files
------------

// File: rtl/str_cic_chan_arb.sv
// Round-robin stream arbiter feeding one shared CIC decimator: each grant
// forwards exactly BURST samples of one channel through a registered output.
module str_cic_chan_arb #(
   parameter int W     = 10,
   parameter int CH    = 4,
   parameter int BURST = 4,
   parameter int IDW   = $clog2(CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH*W-1:0]   s_axis_tdata,
   input  logic [CH-1:0]     s_axis_tvalid,
   output logic [CH-1:0]     s_axis_tready,
   output logic [W-1:0]      m_axis_tdata,
   output logic [IDW-1:0]    m_axis_tid,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              busy
);

   localparam int CNTW = $clog2(BURST + 1);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t          state_reg, state_next;
   logic [IDW-1:0]  ptr_reg, ptr_next;
   logic [IDW-1:0]  g_reg, g_next;
   logic [CNTW-1:0] cnt_reg, cnt_next;

   logic [W-1:0]    chan_data [CH];
   logic            found;
   logic [IDW-1:0]  pick;
   logic            oreg_rdy, ish, osh, burst_end;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_chan
         assign chan_data[gi]     = s_axis_tdata[gi*W +: W];
         assign s_axis_tready[gi] = (state_reg == LOCK) && (g_reg == IDW'(gi)) && oreg_rdy;
      end
   endgenerate

   assign osh       = m_axis_tvalid & m_axis_tready;
   assign oreg_rdy  = osh | ~m_axis_tvalid;
   assign ish       = s_axis_tvalid[g_reg] & s_axis_tready[g_reg];
   assign burst_end = (cnt_reg == CNTW'(BURST - 1));
   assign busy      = (state_reg == LOCK);

   // Scan from the far end back toward ptr so the nearest valid channel wins.
   always_comb begin
      found = 1'b0;
      pick  = ptr_reg;
      for (int k = CH - 1; k >= 0; k--) begin
         if (s_axis_tvalid[(int'(ptr_reg) + k) % CH]) begin
            found = 1'b1;
            pick  = IDW'((int'(ptr_reg) + k) % CH);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      g_next     = g_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            cnt_next = '0;
            if (found) begin
               state_next = LOCK;
               g_next     = pick;
            end
         end
         LOCK: begin
            // No preemption: only a completed burst releases the grant.
            if (ish) begin
               cnt_next = cnt_reg + 1'b1;
               if (burst_end) begin
                  state_next = IDLE;
                  ptr_next   = (g_reg == IDW'(CH - 1)) ? '0 : g_reg + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         ptr_reg   <= '0;
         g_reg     <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         g_reg     <= g_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tid    <= '0;
         m_axis_tlast  <= 1'b0;
      end else if (ish) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= chan_data[g_reg];
         m_axis_tid    <= g_reg;
         m_axis_tlast  <= burst_end;
      end else if (osh) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_str_cic_chan_arb.sv
// Directed bench for str_cic_chan_arb: a burst-level reference model checked
// every cycle, plus hand-computed output sequences per scenario.
module tb_str_cic_chan_arb;

   localparam int W     = 10;
   localparam int CH    = 4;
   localparam int BURST = 4;
   localparam int IDW   = $clog2(CH);
   localparam int QD    = 16;
   localparam int OD    = 64;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CH*W-1:0]   s_axis_tdata = '0;
   logic [CH-1:0]     s_axis_tvalid = '0;
   logic [CH-1:0]     s_axis_tready;
   logic [W-1:0]      m_axis_tdata;
   logic [IDW-1:0]    m_axis_tid;
   logic              m_axis_tlast;
   logic              m_axis_tvalid;
   logic              m_axis_tready = 1'b1;
   logic              busy;

   str_cic_chan_arb #(.W(W), .CH(CH), .BURST(BURST)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tid(m_axis_tid), .m_axis_tlast(m_axis_tlast),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .busy(busy)
   );

   initial forever #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // per-channel sample sources
   int src_data [CH][QD];
   int src_len  [CH];
   int src_pos  [CH];
   int src_start[CH];
   int pops     [CH];
   int drop_ch = -1, drop_after = 0, drop_len = 0, hold_left = 0;
   bit dropped = 0;
   int cyc = 0;

   // observed output transactions
   int out_data[OD];
   int out_tid [OD];
   int out_last[OD];
   int out_n = 0;

   // reference model: grant state plus the expected output register
   bit             e_lock = 0;
   int             e_g = 0, e_ptr = 0, e_cnt = 0;
   bit             e_valid = 0, e_last = 0;
   logic [W-1:0]   e_data = '0;
   int             e_tid = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_out(input int idx, input int d, input int t, input int l);
      if (idx >= out_n) begin
         tests++;
         fails++;
         $display("[TB] FAIL out_missing: got %0d outputs, expected index %0d", out_n, idx);
      end else begin
         chk($sformatf("out%0d_data", idx), out_data[idx], d);
         chk($sformatf("out%0d_tid", idx), out_tid[idx], t);
         chk($sformatf("out%0d_last", idx), out_last[idx], l);
      end
   endtask

   task automatic model_reset();
      e_lock = 0; e_g = 0; e_ptr = 0; e_cnt = 0;
      e_valid = 0; e_last = 0; e_data = '0; e_tid = 0;
      cyc = 0; out_n = 0; hold_left = 0; dropped = 0;
      for (int i = 0; i < CH; i++) pops[i] = 0;
   endtask

   task automatic model_step();
      bit rdy, in_hs, out_hs;
      rdy    = !e_valid || m_axis_tready;
      out_hs = e_valid && m_axis_tready;
      in_hs  = e_lock && s_axis_tvalid[e_g] && rdy;
      if (!e_lock) begin
         for (int k = 0; k < CH; k++) begin
            if (!e_lock && s_axis_tvalid[(e_ptr + k) % CH]) begin
               e_g = (e_ptr + k) % CH;
               e_cnt = 0;
               e_lock = 1;
            end
         end
      end else if (in_hs) begin
         e_data = s_axis_tdata[e_g*W +: W];
         e_tid  = e_g;
         e_last = (e_cnt == BURST - 1);
         e_cnt++;
         if (e_cnt == BURST) begin
            e_lock = 0;
            e_ptr  = (e_g + 1) % CH;
         end
      end
      if (in_hs) e_valid = 1;
      else if (out_hs) e_valid = 0;
   endtask

   task automatic drive_sources();
      for (int i = 0; i < CH; i++) begin
         bit has;
         has = src_pos[i] < src_len[i];
         s_axis_tvalid[i] = has && (cyc >= src_start[i]) && !(i == drop_ch && hold_left > 0);
         s_axis_tdata[i*W +: W] = has ? W'(src_data[i][src_pos[i]]) : '0;
      end
   endtask

   // engine: observe handshakes, advance sources and model at each edge
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         model_reset();
      end else begin
         if (m_axis_tvalid && m_axis_tready) begin
            if (out_n < OD) begin
               out_data[out_n] = int'(m_axis_tdata);
               out_tid[out_n]  = int'(m_axis_tid);
               out_last[out_n] = int'(m_axis_tlast);
            end
            $display("[TB] out #%0d data=%0d tid=%0d last=%0d", out_n, m_axis_tdata, m_axis_tid, m_axis_tlast);
            out_n++;
         end
         model_step();
         for (int i = 0; i < CH; i++) begin
            if (s_axis_tvalid[i] && s_axis_tready[i]) begin
               src_pos[i]++;
               pops[i]++;
            end
         end
         if (hold_left > 0) hold_left--;
         if (drop_ch >= 0 && !dropped && pops[drop_ch] == drop_after) begin
            hold_left = drop_len;
            dropped = 1;
         end
         cyc++;
      end
      #1 drive_sources();
   end

   // compare process on the falling edge
   logic [W-1:0]   prev_data;
   logic [IDW-1:0] prev_tid;
   logic           prev_last;
   bit             prev_stall = 0;

   always @(negedge clk) begin
      logic [CH-1:0] exp_rdy;
      exp_rdy = '0;
      if (e_lock && (!e_valid || m_axis_tready)) exp_rdy[e_g] = 1'b1;
      chk("tvalid", int'(m_axis_tvalid), int'(e_valid));
      chk("busy", int'(busy), int'(e_lock));
      chk("s_tready", int'(s_axis_tready), int'(exp_rdy));
      if (e_valid) begin
         chk("tdata", int'(m_axis_tdata), int'(e_data));
         chk("tid", int'(m_axis_tid), e_tid);
         chk("tlast", int'(m_axis_tlast), int'(e_last));
      end
      if (!rst_n) begin
         chk("rst_tdata", int'(m_axis_tdata), 0);
         chk("rst_tid", int'(m_axis_tid), 0);
         chk("rst_tlast", int'(m_axis_tlast), 0);
      end
      if (prev_stall && rst_n) begin
         chk("stall_valid", int'(m_axis_tvalid), 1);
         chk("stall_data", int'(m_axis_tdata), int'(prev_data));
         chk("stall_tid", int'(m_axis_tid), int'(prev_tid));
         chk("stall_last", int'(m_axis_tlast), int'(prev_last));
      end
      prev_stall = rst_n && m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_tid   = m_axis_tid;
      prev_last  = m_axis_tlast;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic load(input int ch, input int base, input int n, input int start);
      for (int k = 0; k < n && k < QD; k++) src_data[ch][k] = base + k;
      src_len[ch]   = n;
      src_pos[ch]   = 0;
      src_start[ch] = start;
   endtask

   task automatic reset_begin();
      tick();
      rst_n = 1'b0;
      m_axis_tready = 1'b1;
      drop_ch = -1;
      for (int i = 0; i < CH; i++) begin
         src_len[i] = 0; src_pos[i] = 0; src_start[i] = 0;
      end
      repeat (2) tick();
   endtask

   initial begin
      for (int i = 0; i < CH; i++) begin
         src_len[i] = 0; src_pos[i] = 0; src_start[i] = 0; pops[i] = 0;
      end

      // single channel, no backpressure
      reset_begin();
      load(2, 1, 5, 0);
      rst_n = 1'b1;
      repeat (15) tick();
      chk("s1_count", out_n, 5);
      for (int n = 0; n < 4; n++) chk_out(n, n + 1, 2, (n == 3) ? 1 : 0);
      chk_out(4, 5, 2, 0);

      // all channels valid, continuous
      reset_begin();
      for (int i = 0; i < CH; i++) load(i, i * 100 + 1, 8, 0);
      rst_n = 1'b1;
      repeat (50) tick();
      chk("s2_count", out_n, 32);
      for (int n = 0; n < 20; n++)
         chk_out(n, ((n / 4) % 4) * 100 + (n / 16) * 4 + (n % 4) + 1, (n / 4) % 4, (n % 4 == 3) ? 1 : 0);

      // backpressure for 3 cycles mid-burst
      reset_begin();
      load(0, 1, 8, 0);
      rst_n = 1'b1;
      for (int t = 0; t < 50 && out_n < 2; t++) tick();
      chk("s3_reach", int'(out_n >= 2), 1);
      m_axis_tready = 1'b0;
      tick();
      tick();
      chk("s3_stall_sready", int'(s_axis_tready), 0);
      chk("s3_stall_valid", int'(m_axis_tvalid), 1);
      tick();
      m_axis_tready = 1'b1;
      repeat (20) tick();
      chk("s3_count", out_n, 8);
      for (int n = 0; n < 8; n++) chk_out(n, n + 1, 0, (n % 4 == 3) ? 1 : 0);

      // grant holding while the granted channel stalls
      reset_begin();
      load(1, 11, 4, 0);
      load(3, 31, 4, 0);
      drop_ch = 1; drop_after = 2; drop_len = 4;
      rst_n = 1'b1;
      repeat (25) tick();
      chk("s4_count", out_n, 8);
      for (int n = 0; n < 4; n++) chk_out(n, 11 + n, 1, (n == 3) ? 1 : 0);
      for (int n = 0; n < 4; n++) chk_out(4 + n, 31 + n, 3, (n == 3) ? 1 : 0);

      // wrap-around: after ch3, ch0 beats ch2
      reset_begin();
      load(3, 31, 4, 0);
      load(0, 1, 4, 3);
      load(2, 201, 4, 3);
      rst_n = 1'b1;
      repeat (25) tick();
      chk("s5_count", out_n, 12);
      for (int n = 0; n < 4; n++) chk_out(n, 31 + n, 3, (n == 3) ? 1 : 0);
      for (int n = 0; n < 4; n++) chk_out(4 + n, 1 + n, 0, (n == 3) ? 1 : 0);
      for (int n = 0; n < 4; n++) chk_out(8 + n, 201 + n, 2, (n == 3) ? 1 : 0);

      // asynchronous reset in the middle of a ch1 burst
      reset_begin();
      load(1, 11, 8, 0);
      rst_n = 1'b1;
      for (int t = 0; t < 50 && pops[1] < 2; t++) tick();
      chk("s6_reach", int'(pops[1] >= 2), 1);
      chk("s6_pre_valid", int'(m_axis_tvalid), 1);
      #1 rst_n = 1'b0;
      #1;
      chk("s6_async_valid", int'(m_axis_tvalid), 0);
      chk("s6_async_busy", int'(busy), 0);
      chk("s6_async_sready", int'(s_axis_tready), 0);
      load(0, 1, 4, 0);
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (25) tick();
      for (int n = 0; n < 4; n++) chk_out(n, 1 + n, 0, (n == 3) ? 1 : 0);
      chk_out(4, 13, 1, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
